// File: rtl/io_pkg.sv
// Shared I/O definitions for the memory-mapped switch/LED peripherals and the
// switch debounce datapath.
package io_pkg;

    localparam logic [31:0] SW_ADDR   = 32'hC000_0000;
    localparam logic [31:0] LED_ADDR  = 32'hC000_0004;
    localparam logic [31:0] EDGE_ADDR = 32'hC000_0008;

    localparam int N_SW_DEF         = 10;
    localparam int DEBOUNCE_DEF     = 500000;

    // What one debounce slice does on the coming edge.
    typedef enum logic [1:0] {
        DB_MATCH  = 2'd0,
        DB_COUNT  = 2'd1,
        DB_ACCEPT = 2'd2
    } db_action_e;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_conditioner_debounce_bit.sv
// One switch bit: two-stage synchronizer, consecutive-cycle debounce counter
// and the accepted (clean) value. accept is high in the cycle before clean updates.
module debounce_bit
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic accept
);

    localparam int                 CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             clean_q, clean_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    db_action_e       action_s;

    // Next-state for synchronizer, counter and clean value.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        accept  = 1'b0;

        if (sync2_q == clean_q) begin
            action_s = DB_MATCH;
        end else if (cnt_q == CNT_LAST) begin
            action_s = DB_ACCEPT;
        end else begin
            action_s = DB_COUNT;
        end

        // A mismatch that disappears before the count completes restarts from zero.
        case (action_s)
            DB_MATCH: begin
                cnt_d = CNT_ZERO;
            end
            DB_COUNT: begin
                cnt_d = cnt_q + CNT_ONE;
            end
            DB_ACCEPT: begin
                clean_d = sync2_q;
                cnt_d   = CNT_ZERO;
                accept  = 1'b1;
            end
            default: begin
                cnt_d = CNT_ZERO;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= CNT_ZERO;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/switch_conditioner.sv
// Slide-switch conditioner: per-bit synchronize + debounce, a registered change
// pulse, and an optional sticky edge mask enabled by SW_EDGE_CAPTURE_EN.
module switch_conditioner
    import io_pkg::*;
#(
    parameter int N_SW            = N_SW_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_clean,
    output logic            sw_changed,
    output logic [N_SW-1:0] edge_mask,
    input  logic            edge_clr
);

    logic [N_SW-1:0] clean_s;
    logic [N_SW-1:0] accept_s;
    logic            sw_changed_q, sw_changed_d;

    for (genvar i = 0; i < N_SW; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .raw    (sw_raw[i]),
            .clean  (clean_s[i]),
            .accept (accept_s[i])
        );
    end

    // Any bit accepted on this edge becomes a single pulse alongside the new value.
    always_comb begin
        sw_changed_d = |accept_s;
    end

    // Change-pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_changed_q <= 1'b0;
        end else begin
            sw_changed_q <= sw_changed_d;
        end
    end

    assign sw_clean   = clean_s;
    assign sw_changed = sw_changed_q;

`ifdef SW_EDGE_CAPTURE_EN
    logic [N_SW-1:0] edge_mask_q, edge_mask_d;

    // Clear is applied before the OR so a toggle on the clearing edge survives.
    always_comb begin
        edge_mask_d = (edge_mask_q & ~{N_SW{edge_clr}}) | accept_s;
    end

    // Sticky edge flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_mask_q <= {N_SW{1'b0}};
        end else begin
            edge_mask_q <= edge_mask_d;
        end
    end

    assign edge_mask = edge_mask_q;
`else
    logic unused_edge_clr_s;

    assign unused_edge_clr_s = edge_clr;
    assign edge_mask         = {N_SW{1'b0}};
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner: a D=4 instance and a D=1 instance;
// expected change pulses are queued at stimulus time and checked by monitors.
module tb_switch_conditioner;

    typedef struct {
        int         cyc;
        logic [9:0] clean;
        logic [9:0] mask;
    } exp_t;

`ifdef SW_EDGE_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       edge_clr = 1'b0;
    logic [9:0] raw0     = 10'h000;
    logic [9:0] raw1     = 10'h000;
    logic [9:0] clean0, clean1, mask0, mask1;
    logic       chg0, chg1;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    switch_conditioner #(.N_SW(10), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .sw_raw(raw0), .sw_clean(clean0),
        .sw_changed(chg0), .edge_mask(mask0), .edge_clr(edge_clr)
    );

    switch_conditioner #(.N_SW(10), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .sw_raw(raw1), .sw_clean(clean1),
        .sw_changed(chg1), .edge_mask(mask1), .edge_clr(edge_clr)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [9:0] mexp(input logic [9:0] m);
        return CAP ? m : 10'h000;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push0(input int dly, input logic [9:0] c, input logic [9:0] m);
        exp_t e;
        e.cyc = cyc + dly; e.clean = c; e.mask = m;
        q0.push_back(e);
    endtask

    task automatic push1(input int dly, input logic [9:0] c, input logic [9:0] m);
        exp_t e;
        e.cyc = cyc + dly; e.clean = c; e.mask = m;
        q1.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        raw0  = 10'h000;
        raw1  = 10'h000;
        tick(2);
        reset = 1'b0;
    endtask

    // Monitor for the D=4 instance.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (chg0 === 1'b1) begin
            if (q0.size() == 0) begin
                check("d4_unexpected_pulse", {22'd0, clean0}, 32'hFFFF_FFFF);
            end else begin
                e = q0.pop_front();
                check("d4_pulse_cycle", cyc, e.cyc);
                check("d4_pulse_clean", {22'd0, clean0}, {22'd0, e.clean});
                check("d4_pulse_mask",  {22'd0, mask0},  {22'd0, e.mask});
            end
        end else if (q0.size() > 0 && cyc > q0[0].cyc) begin
            e = q0.pop_front();
            check("d4_missing_pulse", cyc, e.cyc);
        end
    end

    // Monitor for the D=1 instance.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (chg1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("d1_unexpected_pulse", {22'd0, clean1}, 32'hFFFF_FFFF);
            end else begin
                e = q1.pop_front();
                check("d1_pulse_cycle", cyc, e.cyc);
                check("d1_pulse_clean", {22'd0, clean1}, {22'd0, e.clean});
                check("d1_pulse_mask",  {22'd0, mask1},  {22'd0, e.mask});
            end
        end else if (q1.size() > 0 && cyc > q1[0].cyc) begin
            e = q1.pop_front();
            check("d1_missing_pulse", cyc, e.cyc);
        end
    end

    initial begin
        // Reset with all switches on, then release and hold.
        raw0 = 10'h3FF;
        tick(3);
        check("rst_clean",   {22'd0, clean0}, 32'd0);
        check("rst_changed", {31'd0, chg0},   32'd0);
        check("rst_mask",    {22'd0, mask0},  32'd0);
        check("rst_clean_d1", {22'd0, clean1}, 32'd0);
        reset = 1'b0;
        push0(6, 10'h3FF, mexp(10'h3FF));
        tick(10);
        check("rst_release_clean", {22'd0, clean0}, 32'h3FF);

        // Short glitch on bit0 must not be accepted.
        do_reset();
        raw0 = 10'h001;
        tick(3);
        raw0 = 10'h000;
        tick(12);
        check("glitch_clean", {22'd0, clean0}, 32'h000);
        check("glitch_mask",  {22'd0, mask0},  32'h000);

        // Independent bits two cycles apart give two pulses.
        do_reset();
        raw0 = 10'h200;
        push0(6, 10'h200, mexp(10'h200));
        tick(2);
        raw0 = 10'h204;
        push0(6, 10'h204, mexp(10'h204));
        tick(10);

        // Edge capture: rise then fall of bit1 leaves its flag set.
        do_reset();
        raw0 = 10'h002;
        push0(6, 10'h002, mexp(10'h002));
        tick(8);
        raw0 = 10'h000;
        push0(6, 10'h000, mexp(10'h002));
        tick(8);
        check("edge_bit1_mask", {22'd0, mask0}, {22'd0, mexp(10'h002)});
        // Clear on the very edge bit3 is accepted.
        raw0 = 10'h008;
        push0(6, 10'h008, mexp(10'h008));
        tick(5);
        edge_clr = 1'b1;
        tick(1);
        edge_clr = 1'b0;
        tick(4);
        check("edge_clr_with_toggle", {22'd0, mask0}, {22'd0, mexp(10'h008)});
        edge_clr = 1'b1;
        tick(1);
        edge_clr = 1'b0;
        tick(1);
        check("edge_clr_alone", {22'd0, mask0}, 32'h000);

        // Reset in the middle of a count restarts the debounce.
        do_reset();
        raw0 = 10'h020;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        push0(6, 10'h020, mexp(10'h020));
        tick(5);
        check("midrst_not_early", {22'd0, clean0}, 32'h000);
        tick(1);
        check("midrst_accepted", {22'd0, clean0}, 32'h020);
        tick(4);

        // D=1 instance: bit4 toggles in three edges each way.
        raw1 = 10'h010;
        push1(3, 10'h010, mexp(10'h010));
        tick(5);
        raw1 = 10'h000;
        push1(3, 10'h000, mexp(10'h010));
        tick(5);
        check("d1_clean_back", {22'd0, clean1}, 32'h000);
        check("d1_mask",       {22'd0, mask1},  {22'd0, mexp(10'h010)});
        edge_clr = 1'b1;
        tick(1);
        edge_clr = 1'b0;
        tick(1);
        check("d1_mask_after_clr", {22'd0, mask1}, 32'h000);
        tick(2);

        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
